// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the IRAM loader and its byte packer.
package iram_loader_pkg;

   localparam int BYTE_W        = 8;
   localparam int CNT_W         = 16;
   localparam int DEF_BASE_ADDR = 1024;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_WRITE,
      ST_CHK,
      ST_FINISH
   } state_e;

   // Running image checksum: XOR of every header and data byte.
   function automatic logic [BYTE_W-1:0] xor_fold(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/iram_loader_byte_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the
// byte that completes a word. Independent of the IRAM so a data-RAM loader can reuse it.
module iram_loader_byte_packer
   import iram_loader_pkg::*;
#(
   parameter int WORD_W = 24
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              shift_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              complete_o
);

   localparam int NB = WORD_W / BYTE_W;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [WORD_W-1:0] word_q, word_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last_s;

   assign last_s     = (cnt_q == CW'(NB - 1));
   assign complete_o = shift_i & last_s;
   assign word_o     = word_q;

   // Next shift-register contents and byte position within the word.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_i) begin
         word_d = (word_q << BYTE_W) | WORD_W'(byte_i);
         cnt_d  = last_s ? CW'(0) : (cnt_q + CW'(1));
      end else begin
         word_d = word_q;
         cnt_d  = cnt_q;
      end
   end

   // Packer state; reset drops any partially assembled word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/iram_loader.sv
// IRAM write-side loader: header + big-endian word stream into IRAM, holding the CPU
// in reset until a complete image lands. IRAM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module iram_loader
   import iram_loader_pkg::*;
#(
   parameter int INSTR_WIDTH = 24,
   parameter int ADDR_WIDTH  = 11,
   parameter int BASE_ADDR   = DEF_BASE_ADDR,
   parameter int MAX_WORDS   = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [BYTE_W-1:0]      s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [ADDR_WIDTH-1:0]  iram_addr,
   output logic [INSTR_WIDTH-1:0] iram_wdata,
   output logic                   iram_we,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_WORDS);

`ifdef IRAM_LOADER_CHECKSUM_EN
   localparam state_e END_ST = ST_CHK;
   logic [BYTE_W-1:0] chk_q, chk_d;
`else
   localparam state_e END_ST = ST_FINISH;
`endif

   state_e                state_q, state_d;
   logic [BYTE_W-1:0]     cnt_hi_q, cnt_hi_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  s_ready_q, s_ready_d;
   logic                  we_q, we_d;
   logic                  hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  xfer_s;
   logic                  arm_s;
   logic                  shift_s;
   logic                  word_done_s;
   logic [CNT_W-1:0]      len_s;

   assign xfer_s  = s_valid & s_ready_q;
   assign arm_s   = (state_q == ST_IDLE) & start;
   assign shift_s = xfer_s & (state_q == ST_DATA);
   assign len_s   = {cnt_hi_q, s_data};

   iram_loader_byte_packer #(
      .WORD_W (INSTR_WIDTH)
   ) u_packer (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (arm_s),
      .shift_i    (shift_s),
      .byte_i     (s_data),
      .word_o     (iram_wdata),
      .complete_o (word_done_s)
   );

   // Load sequencing, plus the registered-output values implied by the next state.
   always_comb begin
      state_d   = state_q;
      cnt_hi_d  = cnt_hi_q;
      rem_d     = rem_q;
      addr_d    = addr_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      s_ready_d = 1'b0;
      we_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               hold_d  = 1'b1;
               addr_d  = BASE_A;
               rem_d   = '0;
               state_d = ST_LEN_HI;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LEN_HI: begin
            if (xfer_s) begin
               cnt_hi_d = s_data;
               state_d  = ST_LEN_LO;
            end else begin
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_LO: begin
            if (!xfer_s) begin
               state_d = ST_LEN_LO;
            end else if (len_s == '0) begin
               state_d = END_ST;
            end else if (len_s > MAX_CNT) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               rem_d   = len_s;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_done_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_WRITE: begin
            addr_d = addr_q + ADDR_ONE;
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = END_ST;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_CHK: begin
`ifdef IRAM_LOADER_CHECKSUM_EN
            if (!xfer_s) begin
               state_d = ST_CHK;
            end else if (s_data == chk_q) begin
               state_d = ST_FINISH;
            end else begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      case (state_d)
         ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK: begin
            s_ready_d = 1'b1;
         end
         ST_WRITE: begin
            we_d = 1'b1;
         end
         ST_FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
         end
         default: begin
            s_ready_d = 1'b0;
            we_d      = 1'b0;
         end
      endcase
   end

   // FSM, counters and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_hi_q  <= '0;
         rem_q     <= '0;
         addr_q    <= BASE_A;
         s_ready_q <= 1'b0;
         we_q      <= 1'b0;
         hold_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_hi_q  <= cnt_hi_d;
         rem_q     <= rem_d;
         addr_q    <= addr_d;
         s_ready_q <= s_ready_d;
         we_q      <= we_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef IRAM_LOADER_CHECKSUM_EN
   // Checksum accumulates every accepted byte of the current image.
   always_comb begin
      chk_d = chk_q;
      if (arm_s) begin
         chk_d = '0;
      end else if (xfer_s) begin
         chk_d = xor_fold(chk_q, s_data);
      end else begin
         chk_d = chk_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end
`endif

   assign s_ready   = s_ready_q;
   assign iram_we   = we_q;
   assign iram_addr = addr_q;
   assign cpu_hold  = hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = err_q;

endmodule
